basemul_acc_fsm: RTL
====================

Name: basemul_acc_fsm

Overview:
Parametrised successor control FSM for the basemul / tomont datapath. It owns its own cycle counter instead of taking one from outside. It sequences K_NUM operand load and compute rounds into RAM C: round 0 overwrites C, and later rounds accumulate into C (matrix-vector row accumulation). Pipeline latency and polynomial pair count are parameters, not hard-coded constants.

Parameters:
N_PAIRS, 128, number of coefficient pairs issued per round
PIPE_LAT, 4, cycles from operand issue to result valid at RAM C write port; must be 1 to N_PAIRS
CW, 8, internal counter width; must satisfy 2^CW > N_PAIRS+PIPE_LAT
K_MAX, 4, maximum accumulation rounds
KW, 3, width of round count and index; must satisfy 2^KW > K_MAX

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
set  in  1  global enable; when 0, state, counter and outputs hold
start  in  1  one-cycle pulse; begins a new job from IDLE or DONE
k_num  in  KW  rounds for this job; sampled on accepted start; 0 is treated as 1, values above K_MAX are clamped to K_MAX
full_in  in  1  RAM A and RAM B loaded for the current round
cal_en  in  1  permission to compute
iscal  out  1  compute in progress (FILL, RUN, DRAIN)
index_ab_ctrl  out  1  FSM drives the A/B read index
index_c_ctrl  out  1  FSM drives the C index (else readout drives it)
rama_we_ok  out  1  RAM A write allowed
ramb_we_ok  out  1  RAM B write allowed
ramc_we_ok  out  1  RAM C write allowed
acc_en  out  1  C write = C + result (0 means overwrite)
readin_ok  out  1  one-cycle pulse requesting the next A/B load
cal_pulse  out  1  one-cycle pulse clearing datapath indices
round_idx  out  KW  current round, 0-based
cnt  out  CW  internal cycle counter
done  out  1  job complete; C valid for readout

Behaviour:
- Reset is synchronous and active-high; it has priority over set. On reset: state=IDLE; all outputs 0; cnt=0; round_idx=0; k_num latch=0. Reset asserted mid-job aborts the job immediately with no further RAM writes.
- All outputs are registered and change on the clock edge of each state transition. With set=0, everything freezes, including pulses that are already high.
- States and transitions:
  - IDLE: start -> LOAD.
  - LOAD: readin_ok=1 for one cycle; rama_we_ok=ramb_we_ok=1. Next state WAIT_FULL.
  - WAIT_FULL: readin_ok=0. full_in -> WAIT_CAL; otherwise stay.
  - WAIT_CAL: rama_we_ok=ramb_we_ok=0. cal_en -> FILL with cal_pulse=1 for one cycle and cnt=0.
  - FILL: iscal=1; index_ab_ctrl=1; cnt increments each cycle. When cnt==PIPE_LAT-1 -> RUN.
  - RUN: index_c_ctrl=1; ramc_we_ok=1; acc_en=(round_idx!=0). When cnt==N_PAIRS-1 -> DRAIN.
  - DRAIN: index_ab_ctrl=0; ramc_we_ok stays 1. When cnt==N_PAIRS+PIPE_LAT-1: if round_idx==k_lat-1 -> DONE, otherwise round_idx+1 and -> LOAD.
  - DONE: iscal=0; ramc_we_ok=0; index_c_ctrl=1 (handed to readout); done=1. start -> LOAD with round_idx=0, done=0, new k_num latched.
- Write count: exactly N_PAIRS ramc_we_ok cycles per round, and exactly PIPE_LAT cycles of ramc_we_ok=1 after index_ab_ctrl falls.
- PIPE_LAT==N_PAIRS is legal: RUN is entered and exited on the same count; no state may be skipped incorrectly.
- Ignored inputs: start while busy (any state other than IDLE or DONE); full_in outside WAIT_FULL; cal_en outside WAIT_CAL.
- If full_in and cal_en are both high in WAIT_FULL, only the WAIT_FULL -> WAIT_CAL transition occurs; cal_en is evaluated the following cycle.
- cnt wraps only through explicit clears, never by overflow.
- Any illegal state encoding recovers to IDLE with all outputs 0.

Optional Feature:
BASEMUL_ACC_PERF_EN: adds output perf_cycles [31:0], which counts clk cycles with set=1 from the accepted start to DONE entry. It clears on accepted start, holds in DONE, saturates at all-ones, and resets to 0. Without the macro, the port and counter do not exist and behaviour is otherwise identical.

Test Plan:
- Reset, then start with k_num=1, full_in after 3 cycles, cal_en immediately (defaults) -> readin_ok high exactly 1 cycle; ramc_we_ok high 128 cycles, all with acc_en=0; done=1 at cnt=131; round_idx=0.
- k_num=3 -> three readin_ok pulses; acc_en=0 during round 0 writes and 1 during rounds 1 and 2; round_idx steps 0,1,2; done after the third drain.
- set low for 5 cycles mid-RUN -> cnt, state and outputs frozen; total ramc_we_ok cycles still 128.
- reset asserted in DRAIN of round 1 -> next cycle all outputs 0, state IDLE; start during the reset cycle is ignored.
- k_num=0 -> one round; k_num=7 -> four rounds (clamped); start pulsed while in RUN -> ignored.
- Parameters N_PAIRS=4, PIPE_LAT=4 -> ramc_we_ok 4 cycles per round, done at cnt=7; with BASEMUL_ACC_PERF_EN defined, perf_cycles matches the bench's own cycle count.

Source files
------------

// File: rtl/basemul_acc_fsm.sv
// basemul_acc_fsm: round sequencer for the basemul/tomont datapath; round 0 overwrites RAM C, later rounds accumulate.
// Define BASEMUL_ACC_PERF_EN to add the perf_cycles job-length counter.
module basemul_acc_fsm #(
  parameter int N_PAIRS  = 128,
  parameter int PIPE_LAT = 4,
  parameter int CW       = 8,
  parameter int K_MAX    = 4,
  parameter int KW       = 3
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          set,
  input  logic          start,
  input  logic [KW-1:0] k_num,
  input  logic          full_in,
  input  logic          cal_en,
  output logic          iscal,
  output logic          index_ab_ctrl,
  output logic          index_c_ctrl,
  output logic          rama_we_ok,
  output logic          ramb_we_ok,
  output logic          ramc_we_ok,
  output logic          acc_en,
  output logic          readin_ok,
  output logic          cal_pulse,
  output logic [KW-1:0] round_idx,
  output logic [CW-1:0] cnt,
  output logic          done
`ifdef BASEMUL_ACC_PERF_EN
  ,
  output logic [31:0]   perf_cycles
`endif
);
  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_WAIT_FULL, S_WAIT_CAL, S_FILL, S_RUN, S_DRAIN, S_DONE} state_t;
  localparam logic [CW-1:0] FILL_END  = CW'(PIPE_LAT - 1);
  localparam logic [CW-1:0] RUN_END   = CW'(N_PAIRS - 1);
  localparam logic [CW-1:0] DRAIN_END = CW'(N_PAIRS + PIPE_LAT - 1);
  state_t        r_state, w_next;
  logic [KW-1:0] r_k, w_k, w_round;
  logic [CW-1:0] w_cnt;
  logic [9:0]    w_out;
  logic          w_start, w_last, w_ramc;
  assign w_start = start && (r_state == S_IDLE || r_state == S_DONE);
  assign w_last  = round_idx == r_k - KW'(1);
  always_comb begin
    w_next  = r_state;
    w_k     = r_k;
    w_round = round_idx;
    w_cnt   = cnt;
    case (r_state)
      S_IDLE, S_DONE: if (w_start) begin
        w_next  = S_LOAD;
        w_round = '0;
        w_k     = k_num == '0 ? KW'(1) : (k_num > KW'(K_MAX) ? KW'(K_MAX) : k_num);
      end
      S_LOAD:      w_next = S_WAIT_FULL;
      S_WAIT_FULL: w_next = full_in ? S_WAIT_CAL : S_WAIT_FULL;
      S_WAIT_CAL: if (cal_en) begin
        w_next = S_FILL;
        w_cnt  = '0;
      end
      // when PIPE_LAT == N_PAIRS the fill end is also the issue end, so go straight to draining
      S_FILL: begin
        w_cnt  = cnt + 1'b1;
        w_next = cnt != FILL_END ? S_FILL : (cnt == RUN_END ? S_DRAIN : S_RUN);
      end
      S_RUN: begin
        w_cnt  = cnt + 1'b1;
        w_next = cnt == RUN_END ? S_DRAIN : S_RUN;
      end
      S_DRAIN: if (cnt == DRAIN_END) begin
        w_next  = w_last ? S_DONE : S_LOAD;
        w_round = w_last ? round_idx : round_idx + 1'b1;
      end else w_cnt = cnt + 1'b1;
      default: w_next = S_IDLE;
    endcase
  end
  assign w_ramc = w_next inside {S_RUN, S_DRAIN};
  assign w_out  = {w_next inside {S_FILL, S_RUN, S_DRAIN}, w_next inside {S_FILL, S_RUN},
                   w_next inside {S_RUN, S_DRAIN, S_DONE}, {2{w_next inside {S_LOAD, S_WAIT_FULL}}},
                   w_ramc, w_ramc && w_round != '0, w_next == S_LOAD,
                   r_state == S_WAIT_CAL && w_next == S_FILL, w_next == S_DONE};
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_k       <= '0;
      round_idx <= '0;
      cnt       <= '0;
      {iscal, index_ab_ctrl, index_c_ctrl, rama_we_ok, ramb_we_ok, ramc_we_ok, acc_en, readin_ok, cal_pulse, done} <= '0;
    end else if (set) begin
      r_state   <= w_next;
      r_k       <= w_k;
      round_idx <= w_round;
      cnt       <= w_cnt;
      {iscal, index_ab_ctrl, index_c_ctrl, rama_we_ok, ramb_we_ok, ramc_we_ok, acc_en, readin_ok, cal_pulse, done} <= w_out;
    end
  end
`ifdef BASEMUL_ACC_PERF_EN
  always_ff @(posedge clk) begin
    if (reset) perf_cycles <= '0;
    else if (set) perf_cycles <= w_start ? '0 :
      (r_state != S_IDLE && r_state != S_DONE && perf_cycles != '1) ? perf_cycles + 1'b1 : perf_cycles;
  end
`endif
endmodule
